bram_port_arbiter: RTL and testbench
====================================

BRAM_PORT_ARBITER -- requirements
Module: bram_port_arbiter

Interface
REQ-001 Parameter NumReq, default 4, number of requesters sharing one BRAM port (2..8).
REQ-002 Parameter DataWidth, default 8, BRAM word width.
REQ-003 Parameter Depth, default 1024, BRAM words; AddrWidth = $clog2(Depth)+1, matching the BRAM address port.
REQ-004 clk_i  in  1  single clock; all state on rising edge.
REQ-005 rst_ni  in  1  asynchronous, active-low reset.
REQ-006 req_valid_i  in  NumReq  per-requester access request.
REQ-007 req_ready_o  out  NumReq  one-hot grant; transfer when valid & ready.
REQ-008 req_write_en_i  in  NumReq  1 = write, 0 = read.
REQ-009 req_addr_i  in  NumReq x AddrWidth  per-requester word address.
REQ-010 req_data_i  in  NumReq x DataWidth  per-requester write data.
REQ-011 rsp_valid_o  out  NumReq  one-hot response strobe, one cycle.
REQ-012 rsp_data_o  out  DataWidth  read data, shared; valid with rsp_valid_o.
REQ-013 rsp_err_o  out  1  out-of-range access flag, valid with rsp_valid_o.
REQ-014 mem_write_en_o / mem_addr_o / mem_data_o  out  1 / AddrWidth / DataWidth  registered drive of one BRAM port.
REQ-015 mem_data_i  in  DataWidth  BRAM port read data (1-cycle BRAM latency).

Function
REQ-016 At most one req_ready_o bit high per cycle; only for a requester with req_valid_i high; grant is combinational from valid and priority pointer.
REQ-017 Round-robin: search starts at pointer; after a transfer, pointer = granted index + 1 mod NumReq; no transfer leaves pointer unchanged.
REQ-018 Throughput one transfer per cycle; a requester holding valid is granted within NumReq cycles.
REQ-019 Transfer at edge N drives mem_* during cycle N+1; rsp_valid_o for that requester pulses at cycle N+2 with rsp_data_o = mem_data_i.
REQ-020 Writes also return a response (ack); rsp_data_o for a write equals the written data (BRAM write-first).
REQ-021 No response backpressure; up to two accesses in flight, tracked by a 2-stage requester-index/err pipeline.
REQ-022 Address >= Depth: no BRAM access (mem_write_en_o = 0, mem_addr_o = 0), response still at N+2 with rsp_err_o = 1, rsp_data_o = 0.
REQ-023 Idle cycle: mem_write_en_o = 0; mem_addr_o/mem_data_o hold last value.

Reset
REQ-024 rst_ni low immediately clears: pointer = 0, req_ready_o = 0, rsp_valid_o = 0, rsp_err_o = 0, rsp_data_o = 0, mem_write_en_o = 0, mem_addr_o = 0, mem_data_o = 0, in-flight pipeline discarded.
REQ-025 Reset mid-operation drops in-flight responses; no response for them after release.
REQ-026 First grant possible in the first cycle after rst_ni deasserts.

Configuration
REQ-027 Macro BRAM_ARB_LOCK_EN defined: extra input req_lock_i (NumReq); a transfer with lock high keeps pointer on that requester so it wins the next arbitration while valid; transfer with lock low, or valid dropped, releases normal rotation.
REQ-028 BRAM_ARB_LOCK_EN undefined: req_lock_i absent; pure round-robin per REQ-017.

Structure
REQ-029 Package bram_arb_pkg holds MaxReq constant, req_idx_t typedef and in-flight pipeline struct (valid, idx, err).
REQ-030 Sub-module rr_arbiter (valid vector + pointer -> one-hot grant, grant index) instantiated once.

Verification
REQ-031 Reset, req 0 writes addr 5 data 0xA5, then reads addr 5 -> write ack at N+2, read rsp_data_o = 0xA5 on rsp_valid_o[0].
REQ-032 All four valid continuously for 8 cycles -> grants 0,1,2,3,0,1,2,3; one rsp_valid_o per cycle in same order, 2-cycle lag.
REQ-033 Req 2 reads addr 1024 -> mem_write_en_o = 0, rsp_valid_o[2] with rsp_err_o = 1, rsp_data_o = 0.
REQ-034 rst_ni pulsed low one cycle after two reads accepted -> no rsp_valid_o follows; pointer restarts at 0.
REQ-035 BRAM_ARB_LOCK_EN: req 1 locks 3 transfers while reqs 0,2 valid -> grants 1,1,1,2,0.
REQ-036 Only req 3 valid -> granted every cycle, back-to-back responses, pointer wraps to 0.

Source files
------------

// File: rtl/bram_arb_pkg.sv
// Shared types for the BRAM port arbiter: requester index width and the
// per-stage record that follows each accepted access to its response.
package bram_arb_pkg;

    localparam int MaxReq      = 8;
    localparam int ReqIdxWidth = $clog2(MaxReq);

    typedef logic [ReqIdxWidth-1:0] req_idx_t;

    // One in-flight access: whether the slot is occupied, who issued it,
    // and whether it was out of range (no BRAM access made).
    typedef struct packed {
        logic     valid;
        req_idx_t idx;
        logic     err;
    } inflight_t;

endpackage

// File: rtl/bram_port_arbiter_if.sv
// Requester-side bundle of the BRAM port arbiter.
// Optional feature macro: BRAM_ARB_LOCK_EN adds the req_lock_i vector.
//
// Handshake: requester i transfers on a rising edge where req_valid_i[i] and
// req_ready_o[i] are both high. req_ready_o is one-hot (or zero) and may only
// be high for a requester whose valid is high. A requester keeps valid and its
// payload stable until it sees ready. Responses have no backpressure:
// rsp_valid_o[i] pulses for one cycle, with rsp_data_o/rsp_err_o valid in
// that same cycle.
interface bram_port_arbiter_if #(
    parameter int NumReq    = 4,
    parameter int DataWidth = 8,
    parameter int AddrWidth = 11
);
    logic [NumReq-1:0]                req_valid_i;
    logic [NumReq-1:0]                req_ready_o;
    logic [NumReq-1:0]                req_write_en_i;
    logic [NumReq-1:0][AddrWidth-1:0] req_addr_i;
    logic [NumReq-1:0][DataWidth-1:0] req_data_i;
`ifdef BRAM_ARB_LOCK_EN
    logic [NumReq-1:0]                req_lock_i;
`endif
    logic [NumReq-1:0]                rsp_valid_o;
    logic [DataWidth-1:0]             rsp_data_o;
    logic                             rsp_err_o;

    modport master (
        output req_valid_i, req_write_en_i, req_addr_i, req_data_i,
`ifdef BRAM_ARB_LOCK_EN
        output req_lock_i,
`endif
        input  req_ready_o, rsp_valid_o, rsp_data_o, rsp_err_o
    );

    modport slave (
        input  req_valid_i, req_write_en_i, req_addr_i, req_data_i,
`ifdef BRAM_ARB_LOCK_EN
        input  req_lock_i,
`endif
        output req_ready_o, rsp_valid_o, rsp_data_o, rsp_err_o
    );
endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: the first valid requester at or after the
// pointer (wrapping) wins. Outputs a one-hot grant and its index.
module rr_arbiter
    import bram_arb_pkg::*;
#(
    parameter int NumReq = 4
) (
    input  logic [NumReq-1:0] valid_i,
    input  req_idx_t          ptr_i,
    output logic [NumReq-1:0] grant_o,
    output req_idx_t          grant_idx_o
);

    // Scan offsets from the pointer; the first hit wins.
    always_comb begin
        logic found;
        int   pos;
        grant_o     = '0;
        grant_idx_o = '0;
        found       = 1'b0;
        for (int off = 0; off < NumReq; off++) begin
            pos = int'(ptr_i) + off;
            if (pos >= NumReq) begin
                pos = pos - NumReq;
            end
            for (int k = 0; k < NumReq; k++) begin
                if (!found && (k == pos) && valid_i[k]) begin
                    found       = 1'b1;
                    grant_o[k]  = 1'b1;
                    grant_idx_o = req_idx_t'(k);
                end
            end
        end
    end

endmodule

// File: rtl/bram_port_arbiter.sv
// Shares one single-port BRAM among NumReq requesters with round-robin
// arbitration. Accepted accesses drive the BRAM one cycle later and their
// response (read data, write echo, or range error) appears one cycle after
// that. Optional feature macro: BRAM_ARB_LOCK_EN lets a requester hold the
// priority pointer across consecutive transfers.
module bram_port_arbiter
    import bram_arb_pkg::*;
#(
    parameter int  NumReq    = 4,
    parameter int  DataWidth = 8,
    parameter int  Depth     = 1024,
    localparam int AddrWidth = $clog2(Depth) + 1
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    bram_port_arbiter_if.slave   req_if,
    output logic                 mem_write_en_o,
    output logic [AddrWidth-1:0] mem_addr_o,
    output logic [DataWidth-1:0] mem_data_o,
    input  logic [DataWidth-1:0] mem_data_i
);

    req_idx_t             ptr_q;
    req_idx_t             ptr_next;
    req_idx_t             grant_idx;
    logic [NumReq-1:0]    grant;
    logic                 fire;
    logic                 sel_write;
    logic                 sel_lock;
    logic                 sel_oor;
    logic [AddrWidth-1:0] sel_addr;
    logic [DataWidth-1:0] sel_data;
    inflight_t            s1_q;
    inflight_t            s2_q;

    rr_arbiter #(.NumReq(NumReq)) u_rr_arbiter (
        .valid_i     (req_if.req_valid_i),
        .ptr_i       (ptr_q),
        .grant_o     (grant),
        .grant_idx_o (grant_idx)
    );

    // Ready is held low while reset is asserted so nothing can transfer.
    assign req_if.req_ready_o = rst_ni ? grant : '0;
    assign fire               = rst_ni & (|grant);

    // Mux the winner's command and work out where the pointer goes next.
    always_comb begin
        sel_write = 1'b0;
        sel_lock  = 1'b0;
        sel_addr  = '0;
        sel_data  = '0;
        for (int i = 0; i < NumReq; i++) begin
            if (grant[i]) begin
                sel_write = req_if.req_write_en_i[i];
                sel_addr  = req_if.req_addr_i[i];
                sel_data  = req_if.req_data_i[i];
`ifdef BRAM_ARB_LOCK_EN
                sel_lock  = req_if.req_lock_i[i];
`endif
            end
        end
        sel_oor = (sel_addr >= AddrWidth'(Depth));
        if (grant_idx == req_idx_t'(NumReq - 1)) begin
            ptr_next = '0;
        end else begin
            ptr_next = grant_idx + 1'b1;
        end
        // A locked transfer keeps priority on the same requester.
        if (sel_lock) begin
            ptr_next = grant_idx;
        end
    end

    // Pointer, BRAM drive registers and the two-stage in-flight pipeline.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ptr_q          <= '0;
            mem_write_en_o <= 1'b0;
            mem_addr_o     <= '0;
            mem_data_o     <= '0;
            s1_q           <= '0;
            s2_q           <= '0;
        end else begin
            s2_q           <= s1_q;
            s1_q.valid     <= fire;
            s1_q.idx       <= grant_idx;
            s1_q.err       <= fire & sel_oor;
            mem_write_en_o <= fire & sel_write & ~sel_oor;
            if (fire) begin
                ptr_q <= ptr_next;
                if (sel_oor) begin
                    mem_addr_o <= '0;
                end else begin
                    mem_addr_o <= sel_addr;
                    mem_data_o <= sel_data;
                end
            end
        end
    end

    // Response strobe goes to the requester recorded two stages back.
    always_comb begin
        req_if.rsp_valid_o = '0;
        for (int i = 0; i < NumReq; i++) begin
            if (s2_q.valid && (s2_q.idx == req_idx_t'(i))) begin
                req_if.rsp_valid_o[i] = 1'b1;
            end
        end
    end

    assign req_if.rsp_err_o  = s2_q.valid & s2_q.err;
    assign req_if.rsp_data_o = (s2_q.valid && !s2_q.err) ? mem_data_i : '0;

endmodule

// File: tb/tb_bram_port_arbiter.sv
// Bench for bram_port_arbiter with a behavioural BRAM and a transaction-level
// reference model (search-order grant, in-order memory image, two-deep
// response history). Define BRAM_ARB_LOCK_EN to also exercise the lock input.
module tb_bram_port_arbiter;

    localparam int NumReq    = 4;
    localparam int DataWidth = 8;
    localparam int Depth     = 1024;
    localparam int AddrWidth = 11;

    logic                 clk_i  = 1'b0;
    logic                 rst_ni = 1'b0;
    logic                 mem_write_en_o;
    logic [AddrWidth-1:0] mem_addr_o;
    logic [DataWidth-1:0] mem_data_o;
    logic [DataWidth-1:0] mem_data_i;

    always #5 clk_i = ~clk_i;

    bram_port_arbiter_if #(
        .NumReq(NumReq), .DataWidth(DataWidth), .AddrWidth(AddrWidth)
    ) bus ();

    bram_port_arbiter #(
        .NumReq(NumReq), .DataWidth(DataWidth), .Depth(Depth)
    ) dut (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .req_if         (bus.slave),
        .mem_write_en_o (mem_write_en_o),
        .mem_addr_o     (mem_addr_o),
        .mem_data_o     (mem_data_o),
        .mem_data_i     (mem_data_i)
    );

    // Write-first single-port BRAM, one cycle read latency.
    logic [DataWidth-1:0] bram [Depth];
    always @(posedge clk_i) begin
        if (mem_write_en_o) begin
            bram[mem_addr_o[9:0]] <= mem_data_o;
            mem_data_i            <= mem_data_o;
        end else begin
            mem_data_i <= bram[mem_addr_o[9:0]];
        end
    end

    // Reference model state.
    typedef struct {
        bit             v;
        int             idx;
        bit             err;
        bit             wr;
        int             addr;
        logic [7:0]     data;
    } xfer_t;

    logic [DataWidth-1:0] ref_mem [Depth];
    int    m_ptr;
    int    m_addr;
    xfer_t h0;
    xfer_t h1;
    int    n_assert = 0;
    int    n_fail   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_reqs();
        bus.req_valid_i    = '0;
        bus.req_write_en_i = '0;
        bus.req_addr_i     = '0;
        bus.req_data_i     = '0;
`ifdef BRAM_ARB_LOCK_EN
        bus.req_lock_i     = '0;
`endif
    endtask

    task automatic set_req(input int i, input bit wr, input int addr, input int data);
        bus.req_valid_i[i]    = 1'b1;
        bus.req_write_en_i[i] = wr;
        bus.req_addr_i[i]     = AddrWidth'(addr);
        bus.req_data_i[i]     = DataWidth'(data);
    endtask

    // Check one cycle of outputs against the model, then advance past one edge.
    task automatic cycle(input string tag);
        int         g;
        int         j;
        xfer_t      t;
        logic [3:0] exp_rdy;
        logic [3:0] exp_rv;
        #1;
        g = -1;
        for (int k = 0; k < NumReq; k++) begin
            j = (m_ptr + k) % NumReq;
            if (g < 0 && bus.req_valid_i[j]) g = j;
        end
        exp_rdy = '0;
        if (g >= 0) exp_rdy[g] = 1'b1;
        exp_rv = '0;
        if (h1.v) exp_rv[h1.idx] = 1'b1;
        chk({tag, ":ready"},     32'(bus.req_ready_o), 32'(exp_rdy));
        chk({tag, ":rsp_valid"}, 32'(bus.rsp_valid_o), 32'(exp_rv));
        chk({tag, ":rsp_err"},   32'(bus.rsp_err_o),   32'(h1.v && h1.err));
        chk({tag, ":rsp_data"},  32'(bus.rsp_data_o),  (h1.v && !h1.err) ? 32'(h1.data) : 32'h0);
        chk({tag, ":mem_we"},    32'(mem_write_en_o),  32'(h0.v && !h0.err && h0.wr));
        chk({tag, ":mem_addr"},  32'(mem_addr_o),      32'(m_addr));
        if (h0.v && !h0.err && h0.wr) chk({tag, ":mem_data"}, 32'(mem_data_o), 32'(h0.data));
        t = '{default: 0};
        if (g >= 0) begin
            t.v    = 1'b1;
            t.idx  = g;
            t.addr = int'(bus.req_addr_i[g]);
            t.wr   = bus.req_write_en_i[g];
            t.err  = (t.addr >= Depth);
            if (t.err) begin
                t.data = '0;
                m_addr = 0;
            end else begin
                if (t.wr) ref_mem[t.addr] = bus.req_data_i[g];
                t.data = ref_mem[t.addr];
                m_addr = t.addr;
            end
            m_ptr = (g + 1) % NumReq;
`ifdef BRAM_ARB_LOCK_EN
            if (bus.req_lock_i[g]) m_ptr = g;
`endif
        end
        h1 = h0;
        h0 = t;
        @(negedge clk_i);
    endtask

    task automatic do_reset(input string tag);
        rst_ni = 1'b0;
        #1;
        chk({tag, ":rst_ready"},    32'(bus.req_ready_o), 32'h0);
        chk({tag, ":rst_rsp_valid"}, 32'(bus.rsp_valid_o), 32'h0);
        chk({tag, ":rst_rsp_err"},  32'(bus.rsp_err_o),   32'h0);
        chk({tag, ":rst_rsp_data"}, 32'(bus.rsp_data_o),  32'h0);
        chk({tag, ":rst_mem_we"},   32'(mem_write_en_o),  32'h0);
        chk({tag, ":rst_mem_addr"}, 32'(mem_addr_o),      32'h0);
        chk({tag, ":rst_mem_data"}, 32'(mem_data_o),      32'h0);
        m_ptr  = 0;
        m_addr = 0;
        h0     = '{default: 0};
        h1     = '{default: 0};
        @(negedge clk_i);
        rst_ni = 1'b1;
    endtask

    initial begin
        logic [3:0] oh;
        int         a;
        clear_reqs();
        m_ptr  = 0;
        m_addr = 0;
        h0     = '{default: 0};
        h1     = '{default: 0};
        @(negedge clk_i);
        do_reset("init");

        // Write 0xA5 to address 5 from requester 0, then read it back.
        set_req(0, 1'b1, 5, 8'hA5);
        cycle("wr5");
        clear_reqs();
        cycle("wr5_gap");
        set_req(0, 1'b0, 5, 0);
        cycle("rd5");
        clear_reqs();
        cycle("rd5_mem");
        #1;
        chk("rd5_lit_valid", 32'(bus.rsp_valid_o), 32'h1);
        chk("rd5_lit_data",  32'(bus.rsp_data_o),  32'hA5);
        cycle("rd5_rsp");

        // Fill addresses 0..15 back-to-back from requester 0.
        for (int i = 0; i < 16; i++) begin
            clear_reqs();
            set_req(0, 1'b1, i, $urandom_range(0, 255));
            cycle("fill");
        end
        clear_reqs();
        cycle("fill_drain0");
        cycle("fill_drain1");

        // All four requesters valid: strict rotation from pointer 0.
        do_reset("rot");
        for (int i = 0; i < NumReq; i++) set_req(i, 1'b0, $urandom_range(0, 15), 0);
        for (int i = 0; i < 8; i++) begin
            oh = '0;
            oh[i % 4] = 1'b1;
            #1;
            chk("rot_lit_grant", 32'(bus.req_ready_o), 32'(oh));
            cycle("rot");
        end
        clear_reqs();
        cycle("rot_drain0");
        cycle("rot_drain1");

        // Out-of-range read from requester 2.
        set_req(2, 1'b0, 1024, 0);
        cycle("oor");
        clear_reqs();
        #1;
        chk("oor_lit_we",   32'(mem_write_en_o), 32'h0);
        chk("oor_lit_addr", 32'(mem_addr_o),     32'h0);
        cycle("oor_mem");
        #1;
        chk("oor_lit_valid", 32'(bus.rsp_valid_o), 32'h4);
        chk("oor_lit_err",   32'(bus.rsp_err_o),   32'h1);
        chk("oor_lit_data",  32'(bus.rsp_data_o),  32'h0);
        cycle("oor_rsp");

        // Only requester 3 valid: granted every cycle, pointer wraps to 0.
        for (int i = 0; i < 5; i++) begin
            clear_reqs();
            set_req(3, 1'b0, $urandom_range(0, 15), 0);
            #1;
            chk("solo3_lit_grant", 32'(bus.req_ready_o), 32'h8);
            cycle("solo3");
        end
        for (int i = 0; i < NumReq; i++) set_req(i, 1'b0, $urandom_range(0, 15), 0);
        #1;
        chk("wrap_lit_grant", 32'(bus.req_ready_o), 32'h1);
        cycle("wrap");
        clear_reqs();
        cycle("wrap_drain0");
        cycle("wrap_drain1");

        // Two reads in flight, then reset: their responses must vanish.
        set_req(0, 1'b0, 3, 0);
        set_req(1, 1'b0, 4, 0);
        cycle("flight0");
        cycle("flight1");
        clear_reqs();
        do_reset("mid");
        for (int i = 0; i < 4; i++) cycle("post_rst");
        for (int i = 0; i < NumReq; i++) set_req(i, 1'b0, $urandom_range(0, 15), 0);
        #1;
        chk("post_rst_lit_grant", 32'(bus.req_ready_o), 32'h1);
        cycle("post_rst_grant");
        clear_reqs();
        cycle("post_rst_drain0");
        cycle("post_rst_drain1");

        // Randomized traffic, including writes, range errors and idle slots.
        for (int n = 0; n < 400; n++) begin
            clear_reqs();
            for (int i = 0; i < NumReq; i++) begin
                if ($urandom_range(0, 99) < 55) begin
                    a = ($urandom_range(0, 9) == 0) ? 1024 + $urandom_range(0, 1023)
                                                    : $urandom_range(0, 15);
                    set_req(i, 1'($urandom_range(0, 1)), a, $urandom_range(0, 255));
`ifdef BRAM_ARB_LOCK_EN
                    bus.req_lock_i[i] = ($urandom_range(0, 3) == 0);
`endif
                end
            end
            cycle("rand");
        end
        clear_reqs();
        for (int i = 0; i < 3; i++) cycle("rand_drain");

`ifdef BRAM_ARB_LOCK_EN
        // Requester 1 locks three transfers while 0 and 2 wait.
        do_reset("lock");
        set_req(0, 1'b0, 1, 0);
        cycle("lock_setup");
        clear_reqs();
        for (int i = 0; i < 3; i++) set_req(i, 1'b0, $urandom_range(0, 15), 0);
        bus.req_lock_i[1] = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("lock_lit_grant1", 32'(bus.req_ready_o), 32'h2);
            cycle("lock_hold");
        end
        bus.req_valid_i[1] = 1'b0;
        bus.req_lock_i[1]  = 1'b0;
        #1;
        chk("lock_lit_grant2", 32'(bus.req_ready_o), 32'h4);
        cycle("lock_rel2");
        #1;
        chk("lock_lit_grant0", 32'(bus.req_ready_o), 32'h1);
        cycle("lock_rel0");
        clear_reqs();
        cycle("lock_drain0");
        cycle("lock_drain1");
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
